// File: rtl/io_bcd_seq_conv.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) with a one-deep write buffer.
// Optional LEADING_ZERO_BLANK_EN: leading zero digits are output as 4'hF (units digit is never blanked).
module io_bcd_seq_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                io_clk,
    input  logic                clrn,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                busy,
    output logic                bcd_valid,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overrun
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    scratch_nx;
    logic [WIDTH-1:0] shift_nx;
    logic [BW-1:0]    disp_bcd;

    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ? scratch_q[gi*4 +: 4] + 4'd3
                                                                : scratch_q[gi*4 +: 4];
    end

    assign {scratch_nx, shift_nx} = {adj, shift_q} << 1;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked only when it and every digit above it are zero.
    assign disp_bcd[3:0] = scratch_nx[3:0];
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
        assign disp_bcd[gi*4 +: 4] = (|scratch_nx[BW-1:gi*4]) ? scratch_nx[gi*4 +: 4] : 4'hF;
    end
`else
    assign disp_bcd = scratch_nx;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign bcd_valid = valid_q;
    assign bcd_out   = bcd_q;
    assign overrun   = wr_en && busy && pend_valid_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        scratch_d    = scratch_q;
        bcd_d        = bcd_q;
        valid_d      = 1'b0;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    shift_d   = wr_data;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = scratch_nx;
                shift_d   = shift_nx;
                cnt_d     = cnt_q - CW'(1);
                if (wr_en) begin
                    pend_d       = wr_data;
                    pend_valid_d = 1'b1;
                end
                // Result is published on the last shift so bcd_out and bcd_valid line up in DONE.
                if (cnt_q == CW'(1)) begin
                    bcd_d   = disp_bcd;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                scratch_d    = '0;
                cnt_d        = CW'(WIDTH);
                pend_valid_d = 1'b0;
                if (wr_en) begin
                    shift_d = wr_data;
                    state_d = ST_SHIFT;
                end else if (pend_valid_q) begin
                    shift_d = pend_q;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            scratch_q    <= '0;
            bcd_q        <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            scratch_q    <= scratch_d;
            bcd_q        <= bcd_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_io_bcd_seq_conv.sv
// Self-checking bench for io_bcd_seq_conv: vector table, random values against a decimal model,
// and cycle-indexed sequences for buffering, overrun, back-to-back and mid-conversion reset.
module tb_io_bcd_seq_conv;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BW     = 4 * DIGITS;

    logic             io_clk = 1'b0;
    logic             clrn = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             busy, bcd_valid, overrun;
    logic [BW-1:0]    bcd_out;

    int tests = 0;
    int fails = 0;

    int            wr_cyc[$];
    int            wr_val[$];
    int            got_cyc[$];
    logic [BW-1:0] got_bcd[$];
    int            ovr_cyc[$];
    logic          busy_hist[$];

    typedef struct {
        int unsigned   value;
        logic [BW-1:0] plain;
    } vec_t;
    vec_t tbl[11];

    always #5 io_clk = ~io_clk;

    io_bcd_seq_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .io_clk    (io_clk),
        .clrn      (clrn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_out   (bcd_out),
        .overrun   (overrun)
    );

    // Decimal digits by repeated division; blanking by counting significant digits.
    function automatic logic [BW-1:0] model(int unsigned v);
        logic [BW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int nd;
            nd = 1;
            x = v / 10;
            while (x != 0) begin
                nd++;
                x = x / 10;
            end
            for (int i = nd; i < DIGITS; i++) r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [BW-1:0] disp(logic [BW-1:0] p);
        logic [BW-1:0] r;
        r = p;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (r[i*4 +: 4] != 4'd0) break;
            r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic int gc(int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1;
    endfunction

    function automatic logic [BW-1:0] gb(int i);
        return (i < got_bcd.size()) ? got_bcd[i] : '1;
    endfunction

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic run_conv(string n, int unsigned v, logic [BW-1:0] e);
        int lat;
        lat = -1;
        tick();
        wr_en = 1'b1;
        wr_data = WIDTH'(v);
        #2;
        chk({n, " idle_before"}, 32'(busy), 32'd0);
        tick();
        wr_en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            #2;
            if (bcd_valid) begin
                lat = k;
                break;
            end
            tick();
        end
        chk({n, " latency"}, 32'(lat), 32'(WIDTH + 1));
        chk({n, " bcd"}, 32'(bcd_out), 32'(e));
        $display("[TB] conv %0d -> %05h (expect %05h, latency %0d)", v, bcd_out, e, lat);
        tick();
        #2;
        chk({n, " idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic run_seq(int ncyc);
        got_cyc.delete();
        got_bcd.delete();
        ovr_cyc.delete();
        busy_hist.delete();
        for (int k = 0; k < ncyc; k++) begin
            tick();
            wr_en = 1'b0;
            foreach (wr_cyc[j]) begin
                if (wr_cyc[j] == k) begin
                    wr_en = 1'b1;
                    wr_data = WIDTH'(wr_val[j]);
                    $display("[TB] seq cycle %0d write %0d", k, wr_val[j]);
                end
            end
            #2;
            busy_hist.push_back(busy);
            if (bcd_valid) begin
                got_cyc.push_back(k);
                got_bcd.push_back(bcd_out);
                $display("[TB] seq cycle %0d result %05h", k, bcd_out);
            end
            if (overrun) ovr_cyc.push_back(k);
        end
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int unsigned v;
        int nvalid;

        tbl[0]  = '{0,     20'h00000};
        tbl[1]  = '{65535, 20'h65535};
        tbl[2]  = '{1234,  20'h01234};
        tbl[3]  = '{42,    20'h00042};
        tbl[4]  = '{7,     20'h00007};
        tbl[5]  = '{9,     20'h00009};
        tbl[6]  = '{99,    20'h00099};
        tbl[7]  = '{10000, 20'h10000};
        tbl[8]  = '{100,   20'h00100};
        tbl[9]  = '{59999, 20'h59999};
        tbl[10] = '{1,     20'h00001};

        // Reset state
        repeat (3) @(posedge io_clk);
        #3;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst bcd_valid", 32'(bcd_valid), 32'd0);
        chk("rst bcd_out", 32'(bcd_out), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        tick();
        clrn = 1'b1;

        foreach (tbl[i]) run_conv($sformatf("tbl%0d", i), tbl[i].value, disp(tbl[i].plain));

        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(0, 65535);
            run_conv($sformatf("rnd%0d", i), v, model(v));
        end

        // Busy window for a single conversion
        wr_cyc = '{0};
        wr_val = '{65535};
        run_seq(20);
        for (int k = 0; k < 20; k++)
            chk($sformatf("busy_win c%0d", k), 32'(busy_hist[k]), 32'((k >= 1 && k <= 17) ? 1 : 0));
        chk("busy_win result", 32'(gb(0)), 32'(model(65535)));

        // Write during a conversion is buffered and converted afterwards
        wr_cyc = '{0, 3};
        wr_val = '{1234, 42};
        run_seq(38);
        chk("pend count", 32'(got_cyc.size()), 32'd2);
        chk("pend c0", 32'(gc(0)), 32'd17);
        chk("pend r0", 32'(gb(0)), 32'(model(1234)));
        chk("pend c1", 32'(gc(1)), 32'd34);
        chk("pend r1", 32'(gb(1)), 32'(model(42)));
        chk("pend overrun", 32'(ovr_cyc.size()), 32'd0);

        // Second buffered write replaces the first and flags overrun
        wr_cyc = '{0, 2, 4};
        wr_val = '{7, 8, 9};
        run_seq(38);
        chk("ovr pulses", 32'(ovr_cyc.size()), 32'd1);
        chk("ovr cycle", 32'((ovr_cyc.size() > 0) ? ovr_cyc[0] : -1), 32'd4);
        chk("ovr count", 32'(got_cyc.size()), 32'd2);
        chk("ovr r0", 32'(gb(0)), 32'(model(7)));
        chk("ovr c1", 32'(gc(1)), 32'd34);
        chk("ovr r1", 32'(gb(1)), 32'(model(9)));

        // Write landing in the DONE cycle chains without a gap
        wr_cyc = '{0, 17};
        wr_val = '{321, 4096};
        run_seq(38);
        chk("b2b count", 32'(got_cyc.size()), 32'd2);
        chk("b2b c0", 32'(gc(0)), 32'd17);
        chk("b2b r0", 32'(gb(0)), 32'(model(321)));
        chk("b2b c1", 32'(gc(1)), 32'd34);
        chk("b2b r1", 32'(gb(1)), 32'(model(4096)));
        chk("b2b overrun", 32'(ovr_cyc.size()), 32'd0);

        // Mid-conversion reset discards everything, including a previous non-zero result
        for (int k = 0; k <= 8; k++) begin
            tick();
            wr_en = (k == 0);
            wr_data = WIDTH'(500);
            if (k == 8) clrn = 1'b0;
        end
        #2;
        chk("midrst bcd_out", 32'(bcd_out), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst valid", 32'(bcd_valid), 32'd0);
        tick();
        clrn = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            #2;
            if (bcd_valid) nvalid++;
        end
        chk("midrst no_valid", 32'(nvalid), 32'd0);
        chk("midrst still_idle", 32'(busy), 32'd0);
        run_conv("after_rst", 99, disp(20'h00099));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
